// File: rtl/icache_pkg.sv
// icache geometry, FSM state type and address field helpers.
// Shared by icache_rsp and icache_refill.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int LINES      = 64;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W    = $clog2(LINES);
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BEATS      = LINE_BYTES / 8;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    LOOKUP,
    REFILL
  } state_e;

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] idx_of(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [BEAT_W-1:0] beat_of(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] s;
    s = a >> 3;
    return (BEATS > 1) ? s[BEAT_W-1:0] : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] line_of(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/defines.sv
// Shared request-type encodings for the uni cache interface.
// Included by every block that decodes i_req_reqtyp.
`ifndef ICACHE_DEFINES_SV
`define ICACHE_DEFINES_SV
`define REQ_READ  1'b0
`define REQ_WRITE 1'b1
`endif

// File: rtl/icache_refill.sv
// Refill sequencer: beat counter, beat request address,
// per-beat write strobe and last-beat pulse.
module icache_refill
  import icache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_active,
  input  logic [ADDR_W-1:0] i_line_addr,
  input  logic              i_mem_ready,
  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BEAT_W-1:0] o_beat,
  output logic              o_wr,
  output logic              o_last
);

  logic [BEAT_W-1:0] beat_q, beat_d;

  // beat handshake, request address and last-beat pulse
  always_comb begin
    o_mem_valid = i_active;
    o_wr        = i_active & i_mem_ready;
    o_last      = o_wr &
                  (beat_q == BEAT_W'(BEATS - 1));
    o_mem_addr  = i_line_addr |
                  (ADDR_W'(beat_q) << 3);
    o_beat      = beat_q;
    beat_d      = beat_q;
    if (i_start) beat_d = '0;
    else if (o_wr) beat_d = beat_q + 1'b1;
  end

  // beat counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) beat_q <= '0;
    else beat_q <= beat_d;
  end

endmodule

// File: rtl/stl_reg.sv
// Plain enabled register with asynchronous active-high reset.
// Reset value is a parameter.
module stl_reg #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // load d when enabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_q <= RST;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/icache_rsp.sv
// Direct-mapped read-only instruction cache on the uni cache port.
// Optional ICACHE_FENCEI_EN adds i_fence_i (invalidate all lines).
`include "defines.sv"

module icache_rsp
  import icache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_reqtyp,
  input  logic [63:0]       i_req_wdata,
  output logic [63:0]       o_req_rdata,
  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ready,
`ifdef ICACHE_FENCEI_EN
  input  logic              i_fence_i,
`endif
  input  logic [63:0]       i_mem_rdata
);

  state_e state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic pend_q, pend_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [63:0] data_q [LINES][BEATS];

  logic [ADDR_W-1:0] line_q, line_d;
  logic line_en;
  logic start, active, mem_wr, mem_last;
  logic [BEAT_W-1:0] beat;
  logic fence;

  logic [INDEX_W-1:0] req_idx, line_idx;
  logic [63:0] word;
  logic hit, is_rd;
  logic unused_ok;

`ifdef ICACHE_FENCEI_EN
  assign fence = i_fence_i;
`else
  assign fence = 1'b0;
`endif

  assign unused_ok = ^{i_req_wdata, i_req_size,
                       i_req_addr[1:0]};

  stl_reg #(.W(ADDR_W)) u_line (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (line_en),
    .i_d   (line_d),
    .o_q   (line_q)
  );

  icache_refill u_refill (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (start),
    .i_active    (active),
    .i_line_addr (line_q),
    .i_mem_ready (i_mem_ready),
    .o_mem_valid (o_mem_valid),
    .o_mem_addr  (o_mem_addr),
    .o_beat      (beat),
    .o_wr        (mem_wr),
    .o_last      (mem_last)
  );

  // tag compare and word select for the live request
  always_comb begin
    req_idx  = idx_of(i_req_addr);
    line_idx = idx_of(line_q);
    active   = (state_q == REFILL);
    is_rd    = (i_req_reqtyp == `REQ_READ);
    hit      = valid_q[req_idx] &&
               (tag_q[req_idx] == tag_of(i_req_addr));
    word     = data_q[req_idx][beat_of(i_req_addr)];
  end

  // lookup/refill next state, valid bits and response
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    pend_d      = pend_q;
    o_req_ready = 1'b0;
    o_req_rdata = '0;
    start       = 1'b0;
    line_en     = 1'b0;
    line_d      = line_of(i_req_addr);
    unique case (state_q)
      LOOKUP: begin
        if (i_req_valid && !fence) begin
          if (!is_rd) begin
            o_req_ready = 1'b1;
          end else if (hit) begin
            o_req_ready = 1'b1;
            o_req_rdata = {32'b0, i_req_addr[2] ?
                           word[63:32] : word[31:0]};
          end
        end
        if (i_req_valid && is_rd && !hit) begin
          start   = 1'b1;
          line_en = 1'b1;
          state_d = REFILL;
        end
        if (fence) valid_d = '0;
      end
      REFILL: begin
        if (fence) pend_d = 1'b1;
        if (mem_last) begin
          state_d = LOOKUP;
          pend_d  = 1'b0;
          if (pend_q || fence) valid_d = '0;
          else valid_d[line_idx] = 1'b1;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  // control state with async reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LOOKUP;
      valid_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  // tag and data arrays, never reset
  always_ff @(posedge i_clk) begin
    if (mem_wr) data_q[line_idx][beat] <= i_mem_rdata;
    if (mem_last) tag_q[line_idx] <= tag_of(line_q);
  end

endmodule

// File: tb/tb_icache_rsp.sv
// Self-checking bench for icache_rsp against a line-level
// cache model and a latency-configurable memory responder.
module tb_icache_rsp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic [1:0]  i_req_size = 2'b10;
  logic        i_req_reqtyp = 1'b0;
  logic [63:0] i_req_wdata = '0;
  logic [63:0] o_req_rdata;
  logic        o_mem_valid;
  logic [31:0] o_mem_addr;
  logic        i_mem_ready = 1'b0;
  logic [63:0] i_mem_rdata = '0;
`ifdef ICACHE_FENCEI_EN
  logic        i_fence_i = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  int lat = 0;
  int wait_cnt = 0;
  int unstable = 0;
  logic [31:0] held = '0;
  logic [31:0] mem_log[$];
  logic [31:0] exp_log[$];

  bit          m_valid[64];
  logic [21:0] m_tag[64];

  always #5 clk = ~clk;

  icache_rsp dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_size   (i_req_size),
    .i_req_reqtyp (i_req_reqtyp),
    .i_req_wdata  (i_req_wdata),
    .o_req_rdata  (o_req_rdata),
    .o_mem_valid  (o_mem_valid),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ready  (i_mem_ready),
`ifdef ICACHE_FENCEI_EN
    .i_fence_i    (i_fence_i),
`endif
    .i_mem_rdata  (i_mem_rdata)
  );

  function automatic logic [63:0] mem64(input logic [31:0] a);
    case (a)
      32'h80000000: return 64'h00000013_00100093;
      32'h80000008: return 64'h0000006f_00000513;
      default:      return {a ^ 32'h5a5a1234, ~a};
    endcase
  endfunction

  // memory: answers each beat after lat wait cycles
  always @(negedge clk) begin
    if (rst || !o_mem_valid) begin
      i_mem_ready = 1'b0;
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) held = o_mem_addr;
      else if (o_mem_addr !== held) unstable++;
      if (wait_cnt >= lat) begin
        i_mem_ready = 1'b1;
        i_mem_rdata = mem64(o_mem_addr);
        mem_log.push_back(o_mem_addr);
        wait_cnt = 0;
      end else begin
        i_mem_ready = 1'b0;
        i_mem_rdata = {$urandom, $urandom};
        wait_cnt++;
      end
    end
  end

  function automatic bit log_eq();
    if (mem_log.size() != exp_log.size()) return 1'b0;
    foreach (exp_log[i])
      if (mem_log[i] !== exp_log[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  // line-level model: appends expected beats, returns word/latency
  task automatic model_read(input logic [31:0] a,
                            output logic [31:0] w,
                            output int cyc);
    int idx;
    logic [21:0] tag;
    logic [31:0] line;
    logic [63:0] d;
    idx  = int'((a >> 4) & 32'h3f);
    tag  = a[31:10];
    line = a & ~32'hf;
    cyc  = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      cyc = 1 + 2 * (lat + 1);
      exp_log.push_back(line);
      exp_log.push_back(line + 32'h8);
      m_valid[idx] = 1'b1;
      m_tag[idx] = tag;
    end
    d = mem64(line + (a & 32'h8));
    w = a[2] ? d[63:32] : d[31:0];
  endtask

  // issue one request at a negedge and wait for ready (bounded)
  task automatic do_req(input logic [31:0] a, input bit wr,
                        output bit ok, output logic [63:0] rd,
                        output int cyc);
    mem_log.delete();
    i_req_valid  = 1'b1;
    i_req_addr   = a;
    i_req_reqtyp = wr;
    i_req_size   = 2'($urandom_range(0, 3));
    i_req_wdata  = {$urandom, $urandom};
    ok = 1'b0;
    rd = '0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      #1;
      if (o_req_ready) begin
        ok = 1'b1;
        rd = o_req_rdata;
      end
      @(negedge clk);
      if (!ok) cyc++;
    end
    i_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (o_mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_valid got=%b want=0", o_mem_valid);
    end
    checks++;
    if (o_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0", o_req_ready);
    end
    checks++;
    if (o_req_rdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h want=0", o_req_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    bit ok;
    logic [63:0] rd;
    logic [31:0] w;
    int cyc, ec;
    lat = 0;
    exp_log.delete();
    model_read(32'h80000000, w, ec);
    do_req(32'h80000000, 1'b0, ok, rd, cyc);
    checks++;
    if (!ok || rd !== 64'h00000000_00100093) begin
      failures++;
      $display("FAIL cold_rdata ok=%b got=%h want=%h",
               ok, rd, 64'h00100093);
    end
    checks++;
    if (cyc != 3 || cyc != ec) begin
      failures++;
      $display("FAIL cold_latency got=%0d want=3", cyc);
    end
    checks++;
    if (mem_log.size() != 2 || mem_log[0] !== 32'h80000000 ||
        mem_log[1] !== 32'h80000008) begin
      failures++;
      $display("FAIL cold_beats got_n=%0d want 80000000,80000008",
               mem_log.size());
    end
  endtask

  task automatic test_hit_b2b();
    bit ok;
    logic [63:0] rd;
    logic [31:0] w;
    int cyc, ec;
    exp_log.delete();
    model_read(32'h80000004, w, ec);
    do_req(32'h80000004, 1'b0, ok, rd, cyc);
    checks++;
    if (!ok || cyc != 0 || rd !== 64'h13) begin
      failures++;
      $display("FAIL hit0 cyc=%0d got=%h want=13 cyc0", cyc, rd);
    end
    checks++;
    if (mem_log.size() != 0) begin
      failures++;
      $display("FAIL hit0_mem got=%0d beats want=0", mem_log.size());
    end
    model_read(32'h8000000c, w, ec);
    do_req(32'h8000000c, 1'b0, ok, rd, cyc);
    checks++;
    if (!ok || cyc != 0 || rd !== 64'h6f) begin
      failures++;
      $display("FAIL hit1 cyc=%0d got=%h want=6f cyc0", cyc, rd);
    end
    checks++;
    if (mem_log.size() != 0) begin
      failures++;
      $display("FAIL hit1_mem got=%0d beats want=0", mem_log.size());
    end
  endtask

  task automatic test_conflict();
    bit ok;
    logic [63:0] rd;
    logic [31:0] w;
    int cyc, ec;
    logic [31:0] addrs[2];
    addrs[0] = 32'h80000400;
    addrs[1] = 32'h80000000;
    lat = 1;
    foreach (addrs[i]) begin
      exp_log.delete();
      model_read(addrs[i], w, ec);
      do_req(addrs[i], 1'b0, ok, rd, cyc);
      checks++;
      if (!ok || rd !== {32'h0, w} || cyc != ec || ec == 0) begin
        failures++;
        $display("FAIL conflict_%0d got=%h/%0d want=%h/%0d",
                 i, rd, cyc, w, ec);
      end
      checks++;
      if (!log_eq() || mem_log[0] !== addrs[i]) begin
        failures++;
        $display("FAIL conflict_beats_%0d got_n=%0d want=%h..",
                 i, mem_log.size(), addrs[i]);
      end
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [63:0] rd;
    logic [31:0] w;
    int cyc, ec;
    do_req(32'h80000000, 1'b1, ok, rd, cyc);
    checks++;
    if (!ok || cyc != 0 || rd !== 64'h0 || mem_log.size() != 0) begin
      failures++;
      $display("FAIL write_rsp cyc=%0d got=%h want=0 cyc0", cyc, rd);
    end
    do_req(32'h80000123, 1'b1, ok, rd, cyc);
    checks++;
    if (!ok || cyc != 0 || rd !== 64'h0 || mem_log.size() != 0) begin
      failures++;
      $display("FAIL write_miss cyc=%0d got=%h want=0 cyc0", cyc, rd);
    end
    exp_log.delete();
    model_read(32'h80000000, w, ec);
    do_req(32'h80000000, 1'b0, ok, rd, cyc);
    checks++;
    if (!ok || cyc != ec || rd !== {32'h0, w}) begin
      failures++;
      $display("FAIL write_after got=%h/%0d want=%h/%0d",
               rd, cyc, w, ec);
    end
  endtask

  task automatic test_addr_change();
    logic [31:0] w0, w1;
    int c0, c1, cyc, nrdy;
    logic [63:0] rd;
    lat = 3;
    unstable = 0;
    exp_log.delete();
    mem_log.delete();
    model_read(32'h80000010, w0, c0);
    model_read(32'h80000100, w1, c1);
    i_req_valid  = 1'b1;
    i_req_reqtyp = 1'b0;
    i_req_addr   = 32'h80000010;
    cyc = 0;
    nrdy = 0;
    rd = '0;
    while (nrdy == 0 && cyc < 200) begin
      if (cyc == 3) i_req_addr = 32'h80000100;
      #1;
      if (o_req_ready) begin
        nrdy++;
        rd = o_req_rdata;
      end
      @(negedge clk);
      if (nrdy == 0) cyc++;
    end
    i_req_valid = 1'b0;
    checks++;
    if (nrdy != 1 || rd !== {32'h0, w1}) begin
      failures++;
      $display("FAIL chg_rdata got=%h want=%h", rd, w1);
    end
    checks++;
    if (cyc != c0 + c1 || cyc != 18) begin
      failures++;
      $display("FAIL chg_latency got=%0d want=18", cyc);
    end
    checks++;
    if (!log_eq()) begin
      failures++;
      $display("FAIL chg_beats got_n=%0d want_n=%0d",
               mem_log.size(), exp_log.size());
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL chg_addr_stable got=%0d changes want=0", unstable);
    end
  endtask

  task automatic test_random();
    bit ok, wr;
    logic [63:0] rd;
    logic [31:0] a, w;
    int cyc, ec;
    for (int n = 0; n < 40; n++) begin
      lat = $urandom_range(0, 2);
      a = 32'h80000000 + ($urandom_range(0, 3) << 10) +
          ($urandom_range(0, 3) << 4) + $urandom_range(0, 15);
      wr = ($urandom_range(0, 4) == 0);
      exp_log.delete();
      if (wr) begin
        w = '0;
        ec = 0;
      end else begin
        model_read(a, w, ec);
      end
      do_req(a, wr, ok, rd, cyc);
      checks++;
      if (!ok || rd !== {32'h0, w}) begin
        failures++;
        $display("FAIL rnd_data n=%0d a=%h got=%h want=%h",
                 n, a, rd, w);
      end
      checks++;
      if (cyc != ec) begin
        failures++;
        $display("FAIL rnd_latency n=%0d a=%h got=%0d want=%0d",
                 n, a, cyc, ec);
      end
      checks++;
      if (!log_eq()) begin
        failures++;
        $display("FAIL rnd_beats n=%0d a=%h got_n=%0d want_n=%0d",
                 n, a, mem_log.size(), exp_log.size());
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [63:0] rd;
    logic [31:0] w;
    int cyc, ec, t;
    lat = 3;
    mem_log.delete();
    i_req_valid  = 1'b1;
    i_req_reqtyp = 1'b0;
    i_req_addr   = 32'h80003000;
    t = 0;
    while (mem_log.size() < 1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mem_log.size() < 1) begin
      failures++;
      $display("FAIL rstmid_timeout got=%0d beats want=1",
               mem_log.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (o_mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy got=%b want=1", o_mem_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drop got=%b want=0", o_mem_valid);
    end
    i_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    lat = 1;
    exp_log.delete();
    model_read(32'h80000000, w, ec);
    do_req(32'h80000000, 1'b0, ok, rd, cyc);
    checks++;
    if (!ok || rd !== 64'h00100093 || cyc != 5 || cyc != ec) begin
      failures++;
      $display("FAIL rstmid_refetch got=%h/%0d want=00100093/5",
               rd, cyc);
    end
    checks++;
    if (!log_eq()) begin
      failures++;
      $display("FAIL rstmid_beats got_n=%0d want_n=%0d",
               mem_log.size(), exp_log.size());
    end
  endtask

`ifdef ICACHE_FENCEI_EN
  task automatic test_fence();
    bit ok;
    logic [63:0] rd;
    logic [31:0] w;
    int cyc, ec, t;
    lat = 1;
    i_req_valid  = 1'b1;
    i_req_reqtyp = 1'b0;
    i_req_addr   = 32'h80000000;
    i_fence_i    = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL fence_lookup_ready got=%b want=0", o_req_ready);
    end
    @(negedge clk);
    i_fence_i = 1'b0;
    model_clear();
    exp_log.delete();
    model_read(32'h80000000, w, ec);
    do_req(32'h80000000, 1'b0, ok, rd, cyc);
    checks++;
    if (!ok || rd !== {32'h0, w} || cyc != ec || ec == 0) begin
      failures++;
      $display("FAIL fence_lookup_miss got=%h/%0d want=%h/%0d",
               rd, cyc, w, ec);
    end
    exp_log.delete();
    model_read(32'h80000400, w, ec);
    do_req(32'h80000400, 1'b0, ok, rd, cyc);
    mem_log.delete();
    i_req_valid = 1'b1;
    i_req_addr  = 32'h80000000;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_fence_i   = 1'b1;
    @(negedge clk);
    i_fence_i   = 1'b0;
    t = 0;
    while (o_mem_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (o_mem_valid !== 1'b0 || mem_log.size() != 2) begin
      failures++;
      $display("FAIL fence_refill_done got=%0d beats want=2",
               mem_log.size());
    end
    @(negedge clk);
    model_clear();
    exp_log.delete();
    model_read(32'h80000000, w, ec);
    do_req(32'h80000000, 1'b0, ok, rd, cyc);
    checks++;
    if (!ok || rd !== 64'h00100093 || cyc != 5 || !log_eq()) begin
      failures++;
      $display("FAIL fence_refill_miss got=%h/%0d want=00100093/5",
               rd, cyc);
    end
  endtask
`endif

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_hit_b2b();
    test_conflict();
    test_write();
    test_addr_change();
    test_random();
    test_reset_mid();
`ifdef ICACHE_FENCEI_EN
    test_fence();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
